matrix_operand_loader: RTL and testbench

//  Upstream feeder for the combinational matrix add/sub stage. Accepts matrix elements one word
//  per beat over a valid/ready stream: first all of A, then all of B, row-major.

---
 rtl/matrix_pkg.sv | 15 +
 rtl/matrix_operand_loader.sv | 130 +++++++++++++
 tb/tb_matrix_operand_loader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared state encoding and packing helper for the matrix add/sub datapath
package matrix_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FULL   = 2'd2
    } state_t;

    // Element 0 sits at the MSB end of the flat bus.
    function automatic int elem_msb(input int k, input int n, input int w);
        return n * w - 1 - k * w;
    endfunction

endpackage

// File: rtl/matrix_operand_loader.sv
// rtl/matrix_operand_loader.sv - packs streamed A/B elements into flat operand buses for the add/sub stage
module matrix_operand_loader
    import matrix_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ROWS      = 2,
    parameter int COLS      = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WORD_SIZE-1:0]            in_data,
    input  logic                            in_sof,
    input  logic                            in_op,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ROWS*COLS*WORD_SIZE-1:0]  A_flat,
    output logic [ROWS*COLS*WORD_SIZE-1:0]  B_flat,
    output logic                            op_out,
    output logic                            sync_err
);

    localparam int N     = ROWS * COLS;
    localparam int FW    = N * WORD_SIZE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FW-1:0]      a_q, a_d;
    logic [FW-1:0]      b_q, b_d;
    logic               op_q, op_d;
    logic               err_q, err_d;

    logic               accept;
    logic               wr_a, wr_b;
    logic [IDX_W-1:0]   wr_idx;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        err_d   = 1'b0;
        wr_a    = 1'b0;
        wr_b    = 1'b0;
        wr_idx  = idx_q;
        accept  = in_valid && (state_q != FULL);

        case (state_q)
            LOAD_A, LOAD_B: begin
                if (accept) begin
                    if (in_sof && (state_q == LOAD_B || idx_q != '0)) begin
                        // Out-of-place start: drop the partial set and restart on this beat.
                        err_d  = 1'b1;
                        wr_a   = 1'b1;
                        wr_idx = '0;
                        op_d   = in_op;
                        if (N == 1) begin
                            state_d = LOAD_B;
                            idx_d   = '0;
                        end else begin
                            state_d = LOAD_A;
                            idx_d   = IDX_W'(1);
                        end
                    end else begin
                        wr_a = (state_q == LOAD_A);
                        wr_b = (state_q == LOAD_B);
                        if (state_q == LOAD_A && idx_q == '0) begin
                            op_d = in_op;
                        end
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            state_d = (state_q == LOAD_A) ? LOAD_B : FULL;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_d = LOAD_A;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = LOAD_A;
                idx_d   = '0;
            end
        endcase

        for (int k = 0; k < N; k++) begin
            if (wr_a && wr_idx == IDX_W'(k)) begin
                a_d[elem_msb(k, N, WORD_SIZE) -: WORD_SIZE] = in_data;
            end
            if (wr_b && wr_idx == IDX_W'(k)) begin
                b_d[elem_msb(k, N, WORD_SIZE) -: WORD_SIZE] = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q == FULL);
    assign A_flat    = a_q;
    assign B_flat    = b_q;
    assign op_out    = op_q;
    assign sync_err  = err_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb/tb_matrix_operand_loader.sv - directed self-checking bench for matrix_operand_loader
module tb_matrix_operand_loader;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_sof;
    logic         in_op;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] A_flat;
    logic [127:0] B_flat;
    logic         op_out;
    logic         sync_err;

    int checks = 0;
    int passed = 0;

    matrix_operand_loader #(.WORD_SIZE(32), .ROWS(2), .COLS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A_flat    (A_flat),
        .B_flat    (B_flat),
        .op_out    (op_out),
        .sync_err  (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_beat(input logic [31:0] d, input logic sof, input logic op);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) $display("FAIL beat_ready_timeout actual=%b required=1", in_ready);
        else passed++;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        in_op    = op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_op    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || A_flat !== 128'h0 || B_flat !== 128'h0 ||
            op_out !== 1'b0 || sync_err !== 1'b0)
            $display("FAIL reset_init actual ov=%b ir=%b A=%h B=%h op=%b se=%b required ov=0 ir=1 A=0 B=0 op=0 se=0",
                     out_valid, in_ready, A_flat, B_flat, op_out, sync_err);
        else passed++;
        rst_n = 1'b1;
        send_beat(32'h11, 1'b1, 1'b1);
        send_beat(32'h12, 1'b0, 1'b0);
        send_beat(32'h13, 1'b0, 1'b0);
        send_beat(32'h14, 1'b0, 1'b0);
        send_beat(32'h15, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || A_flat !== 128'h0 || B_flat !== 128'h0 || op_out !== 1'b0)
            $display("FAIL reset_mid_load actual ov=%b ir=%b A=%h B=%h op=%b required ov=0 ir=1 A=0 B=0 op=0",
                     out_valid, in_ready, A_flat, B_flat, op_out);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_add_set();
        out_ready = 1'b1;
        send_beat(32'd1, 1'b1, 1'b0);
        send_beat(32'd2, 1'b0, 1'b0);
        send_beat(32'd3, 1'b0, 1'b0);
        send_beat(32'd4, 1'b0, 1'b0);
        send_beat(32'd10, 1'b0, 1'b0);
        send_beat(32'd20, 1'b0, 1'b0);
        send_beat(32'd30, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL add_early_valid actual=%b required=0", out_valid);
        else passed++;
        send_beat(32'd40, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || op_out !== 1'b0)
            $display("FAIL add_valid actual ov=%b op=%b required ov=1 op=0", out_valid, op_out);
        else passed++;
        checks++;
        if (A_flat !== 128'h00000001_00000002_00000003_00000004)
            $display("FAIL add_A actual=%h required=%h", A_flat, 128'h00000001_00000002_00000003_00000004);
        else passed++;
        checks++;
        if (B_flat !== 128'h0000000A_00000014_0000001E_00000028)
            $display("FAIL add_B actual=%h required=%h", B_flat, 128'h0000000A_00000014_0000001E_00000028);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL add_release actual ov=%b ir=%b required ov=0 ir=1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_beat(32'd5, 1'b1, 1'b1);
        send_beat(32'd6, 1'b0, 1'b0);
        send_beat(32'd7, 1'b0, 1'b0);
        send_beat(32'd8, 1'b0, 1'b0);
        send_beat(32'd9, 1'b0, 1'b0);
        send_beat(32'd10, 1'b0, 1'b0);
        send_beat(32'd11, 1'b0, 1'b0);
        send_beat(32'd12, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_sof   = 1'b1;
        in_op    = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || op_out !== 1'b1 || sync_err !== 1'b0 ||
                A_flat !== 128'h00000005_00000006_00000007_00000008 ||
                B_flat !== 128'h00000009_0000000A_0000000B_0000000C)
                $display("FAIL bp_hold cycle=%0d actual ir=%b ov=%b op=%b se=%b A=%h B=%h required ir=0 ov=1 op=1 se=0 A=5_6_7_8 B=9_A_B_C",
                         c, in_ready, out_valid, op_out, sync_err, A_flat, B_flat);
            else passed++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release actual ir=%b ov=%b required ir=1 ov=0", in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_resync();
        out_ready = 1'b1;
        send_beat(32'd1, 1'b1, 1'b0);
        send_beat(32'd2, 1'b0, 1'b0);
        send_beat(32'hAA, 1'b1, 1'b1);
        checks++;
        if (sync_err !== 1'b1 || A_flat[127:96] !== 32'hAA || op_out !== 1'b1)
            $display("FAIL resync_err actual se=%b A0=%h op=%b required se=1 A0=000000aa op=1",
                     sync_err, A_flat[127:96], op_out);
        else passed++;
        send_beat(32'hBB, 1'b0, 1'b0);
        checks++;
        if (sync_err !== 1'b0) $display("FAIL resync_pulse_width actual=%b required=0", sync_err);
        else passed++;
        send_beat(32'hCC, 1'b0, 1'b0);
        send_beat(32'hDD, 1'b0, 1'b0);
        send_beat(32'd5, 1'b0, 1'b0);
        send_beat(32'd6, 1'b0, 1'b0);
        send_beat(32'd7, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL resync_early_valid actual=%b required=0", out_valid);
        else passed++;
        send_beat(32'd8, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || op_out !== 1'b1 || A_flat !== 128'h000000AA_000000BB_000000CC_000000DD ||
            B_flat !== 128'h00000005_00000006_00000007_00000008)
            $display("FAIL resync_set actual ov=%b op=%b A=%h B=%h required ov=1 op=1 A=aa_bb_cc_dd B=5_6_7_8",
                     out_valid, op_out, A_flat, B_flat);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stalls();
        logic [31:0] vals [8];
        vals = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 32'd20, 32'd30, 32'd40};
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            in_sof   = (i == 0);
            in_op    = 1'b0;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_sof   = 1'b0;
            if (i == 7) begin
                checks++;
                if (out_valid !== 1'b1) $display("FAIL stall_valid actual=%b required=1", out_valid);
                else passed++;
            end
            @(posedge clk);
            #1;
            if (i == 6) begin
                checks++;
                if (out_valid !== 1'b0) $display("FAIL stall_early_valid actual=%b required=0", out_valid);
                else passed++;
            end
        end
        checks++;
        if (A_flat !== 128'h00000001_00000002_00000003_00000004 ||
            B_flat !== 128'h0000000A_00000014_0000001E_00000028 || op_out !== 1'b0)
            $display("FAIL stall_flats actual A=%h B=%h op=%b required A=1_2_3_4 B=a_14_1e_28 op=0",
                     A_flat, B_flat, op_out);
        else passed++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int beat = 0;
        int first = -1;
        int second = -1;
        logic prev_ov = 1'b0;
        logic rdy;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            in_valid = (beat < 16);
            in_data  = (beat < 8) ? 32'(beat + 1) : 32'(32'h100 + beat - 8);
            in_sof   = (beat % 8 == 0);
            in_op    = 1'b0;
            rdy      = in_ready;
            @(posedge clk);
            #1;
            if (in_valid && rdy) beat++;
            if (out_valid && !prev_ov) begin
                if (first < 0) first = cyc;
                else if (second < 0) begin
                    second = cyc;
                    checks++;
                    if (A_flat !== 128'h00000100_00000101_00000102_00000103)
                        $display("FAIL b2b_second_A actual=%h required=%h", A_flat,
                                 128'h00000100_00000101_00000102_00000103);
                    else passed++;
                end
            end
            prev_ov = out_valid;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        checks++;
        if (first != 8) $display("FAIL b2b_first_latency actual=%0d required=8", first);
        else passed++;
        checks++;
        if (second < 0 || second - first != 9)
            $display("FAIL b2b_spacing actual=%0d required=9", (second < 0) ? -1 : second - first);
        else passed++;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sof    = 1'b0;
        in_op     = 1'b0;
        out_ready = 1'b0;
        #2;
        test_reset();
        test_add_set();
        test_backpressure();
        test_resync();
        test_stalls();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
